// File: rtl/ps2_arrow_decoder_if.sv
// rtl/ps2_arrow_decoder_if.sv - PS/2 pins and decoded key-level outputs
interface ps2_arrow_decoder_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       up;
    logic       down;
    logic       right;
    logic       left;
    logic [7:0] scan_code;
    logic       code_valid;
    logic       frame_err;

    modport master (
        input  ps2_clk, ps2_data,
        output up, down, right, left, scan_code, code_valid, frame_err
    );

    modport slave (
        output ps2_clk, ps2_data,
        input  up, down, right, left, scan_code, code_valid, frame_err
    );
endinterface

// File: rtl/ps2_arrow_decoder.sv
// rtl/ps2_arrow_decoder.sv - PS/2 receiver with E0/F0 tracking, arrow/WASD held-key levels
module ps2_arrow_decoder #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                resetN,
    ps2_arrow_decoder_if.master bus
);
    localparam int FW     = $clog2(FILTER_LEN + 1);
    localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TW     = (TW_RAW > 16) ? TW_RAW : 16;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state, state_n;
    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt, filt_d, fall;
    logic [FW-1:0] fcnt;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          par_ok;
    logic [TW-1:0] to_cnt;
    logic          ext, brk;
    logic [3:0]    dir;
    logic [7:0]    scan_q;
    logic          cv_q, fe_q;
    logic          shift_en, par_en, good, bad, timeout;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= bus.ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= bus.ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Filtered level flips only after FILTER_LEN consecutive disagreeing samples
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            filt   <= 1'b1;
            filt_d <= 1'b1;
            fcnt   <= '0;
            fall   <= 1'b0;
        end else begin
            filt_d <= filt;
            fall   <= filt_d & ~filt;
            if (clk_s2 == filt) begin
                fcnt <= '0;
            end else if (fcnt == FW'(FILTER_LEN - 1)) begin
                filt <= clk_s2;
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n  = state;
        shift_en = 1'b0;
        par_en   = 1'b0;
        good     = 1'b0;
        bad      = 1'b0;
        timeout  = (state != IDLE) && !fall && (to_cnt >= TW'(TIMEOUT_CYCLES - 1));
        case (state)
            IDLE:   if (fall && !dat_s2) state_n = DATA;
            DATA:   if (fall) begin
                        shift_en = 1'b1;
                        if (bitcnt == 3'd7) state_n = PARITY;
                    end
            PARITY: if (fall) begin
                        par_en  = 1'b1;
                        state_n = STOP;
                    end
            STOP:   if (fall) begin
                        if (par_ok && dat_s2) good = 1'b1;
                        else                  bad  = 1'b1;
                        state_n = IDLE;
                    end
            default: state_n = IDLE;
        endcase
        if (timeout) state_n = IDLE;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            bitcnt <= '0;
            shreg  <= '0;
            par_ok <= 1'b0;
            to_cnt <= '0;
            cv_q   <= 1'b0;
            fe_q   <= 1'b0;
            scan_q <= '0;
        end else begin
            if (state == IDLE) bitcnt <= '0;
            if (timeout) begin
                shreg <= '0;
            end else if (shift_en) begin
                shreg  <= {dat_s2, shreg[7:1]};
                bitcnt <= bitcnt + 1'b1;
            end
            if (par_en) par_ok <= ^{shreg, dat_s2};
            if (state == IDLE || fall) to_cnt <= '0;
            else                       to_cnt <= to_cnt + 1'b1;
            cv_q <= good;
            fe_q <= bad | timeout;
            if (good) scan_q <= shreg;
        end
    end

    // Prefix tracking and key map; dir is {up, down, right, left}
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ext <= 1'b0;
            brk <= 1'b0;
            dir <= '0;
        end else if (bad || timeout) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (good) begin
            if (shreg == 8'hE0) begin
                ext <= 1'b1;
            end else if (shreg == 8'hF0) begin
                brk <= 1'b1;
            end else begin
                case ({ext, shreg})
                    9'h175:  dir[3] <= ~brk;
                    9'h172:  dir[2] <= ~brk;
                    9'h174:  dir[1] <= ~brk;
                    9'h16B:  dir[0] <= ~brk;
                    9'h01D:  dir[3] <= ~brk;
                    9'h01B:  dir[2] <= ~brk;
                    9'h023:  dir[1] <= ~brk;
                    9'h01C:  dir[0] <= ~brk;
                    default: ;
                endcase
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end
    end

    assign bus.up         = dir[3];
    assign bus.down       = dir[2];
    assign bus.right      = dir[1];
    assign bus.left       = dir[0];
    assign bus.scan_code  = scan_q;
    assign bus.code_valid = cv_q;
    assign bus.frame_err  = fe_q;
endmodule

// File: tb/tb_ps2_arrow_decoder.sv
// tb/tb_ps2_arrow_decoder.sv - self-checking bench for ps2_arrow_decoder
module tb_ps2_arrow_decoder;
    localparam int FILTER_LEN     = 4;
    localparam int TIMEOUT_CYCLES = 1000;
    localparam int HALF           = 25;

    localparam logic [7:0] EXT_MAP [4] = '{8'h75, 8'h72, 8'h74, 8'h6B};
    localparam logic [7:0] STD_MAP [4] = '{8'h1D, 8'h1B, 8'h23, 8'h1C};
    localparam logic [7:0] POOL [10]   = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h74,
                                           8'h6B, 8'h1D, 8'h1B, 8'h23, 8'h1C};

    typedef struct {
        logic [7:0] code;
        bit         bad_par;
        logic [3:0] exp_dir;
        logic [7:0] exp_scan;
        bit         exp_err;
    } vec_t;

    logic clk    = 1'b0;
    logic resetN = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cv_cnt   = 0;
    int   fe_cnt   = 0;

    bit         held [4];
    bit         m_ext, m_brk;
    logic [7:0] m_scan;
    vec_t       tbl [13];

    ps2_arrow_decoder_if bus ();

    ps2_arrow_decoder #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk   (clk),
        .resetN(resetN),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetN) begin
            if (bus.code_valid) cv_cnt++;
            if (bus.frame_err)  fe_cnt++;
            if (bus.code_valid || bus.frame_err)
                check("pulse_exclusive", 32'(bus.code_valid & bus.frame_err), 32'd0);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [3:0] dir_now();
        return {bus.up, bus.down, bus.right, bus.left};
    endfunction

    // Device-to-host frame: start, 8 data LSB first, odd parity, stop
    task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop,
                              input bit glitch, input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_data = f[i];
            if (glitch) begin
                wait_cyc(HALF / 2);
                bus.ps2_clk = 1'b0;
                wait_cyc(2);
                bus.ps2_clk = 1'b1;
                wait_cyc(HALF - HALF / 2 - 2);
            end else begin
                wait_cyc(HALF);
            end
            bus.ps2_clk = 1'b0;
            wait_cyc(HALF);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
        wait_cyc(20);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) held[k] = 1'b0;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_scan = 8'h00;
    endtask

    function automatic int key_index(input bit e, input logic [7:0] c);
        for (int k = 0; k < 4; k++)
            if ((e && EXT_MAP[k] == c) || (!e && STD_MAP[k] == c)) return k;
        return -1;
    endfunction

    task automatic model_apply(input logic [7:0] code, input bit ok);
        int k;
        if (!ok) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else begin
            m_scan = code;
            if (code == 8'hE0)      m_ext = 1'b1;
            else if (code == 8'hF0) m_brk = 1'b1;
            else begin
                k = key_index(m_ext, code);
                if (k >= 0) held[k] = !m_brk;
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
        end
    endtask

    task automatic send_and_check(input logic [7:0] code, input bit bad_par, input bit glitch);
        int cv0, fe0;
        cv0 = cv_cnt;
        fe0 = fe_cnt;
        send_frame(code, bad_par, 1'b0, glitch, 11);
        model_apply(code, !bad_par);
        check("model_dir", 32'(dir_now()), 32'({held[0], held[1], held[2], held[3]}));
        check("model_scan", 32'(bus.scan_code), 32'(m_scan));
        check("model_cv", cv_cnt - cv0, bad_par ? 0 : 1);
        check("model_fe", fe_cnt - fe0, bad_par ? 1 : 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cv0, fe0, pick;
        logic [7:0] code;

        tbl[0]  = '{8'hE0, 1'b0, 4'b0000, 8'hE0, 1'b0};
        tbl[1]  = '{8'h75, 1'b0, 4'b1000, 8'h75, 1'b0};
        tbl[2]  = '{8'hE0, 1'b0, 4'b1000, 8'hE0, 1'b0};
        tbl[3]  = '{8'hF0, 1'b0, 4'b1000, 8'hF0, 1'b0};
        tbl[4]  = '{8'h75, 1'b0, 4'b0000, 8'h75, 1'b0};
        tbl[5]  = '{8'h1C, 1'b0, 4'b0001, 8'h1C, 1'b0};
        tbl[6]  = '{8'h1B, 1'b0, 4'b0101, 8'h1B, 1'b0};
        tbl[7]  = '{8'hF0, 1'b0, 4'b0101, 8'hF0, 1'b0};
        tbl[8]  = '{8'h1C, 1'b0, 4'b0100, 8'h1C, 1'b0};
        tbl[9]  = '{8'hE0, 1'b1, 4'b0100, 8'h1C, 1'b1};
        tbl[10] = '{8'h75, 1'b0, 4'b0100, 8'h75, 1'b0};
        tbl[11] = '{8'hF0, 1'b0, 4'b0100, 8'hF0, 1'b0};
        tbl[12] = '{8'h1B, 1'b0, 4'b0000, 8'h1B, 1'b0};

        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        resetN       = 1'b0;
        wait_cyc(3);
        check("reset_dir", 32'(dir_now()), 32'd0);
        check("reset_scan", 32'(bus.scan_code), 32'h00);
        check("reset_cv", 32'(bus.code_valid), 32'd0);
        check("reset_fe", 32'(bus.frame_err), 32'd0);
        resetN = 1'b1;
        wait_cyc(10);

        for (int i = 0; i < 13; i++) begin
            cv0 = cv_cnt;
            fe0 = fe_cnt;
            send_frame(tbl[i].code, tbl[i].bad_par, 1'b0, 1'b0, 11);
            check($sformatf("vec%0d_dir", i), 32'(dir_now()), 32'(tbl[i].exp_dir));
            check($sformatf("vec%0d_scan", i), 32'(bus.scan_code), 32'(tbl[i].exp_scan));
            check($sformatf("vec%0d_cv", i), cv_cnt - cv0, tbl[i].exp_err ? 0 : 1);
            check($sformatf("vec%0d_fe", i), fe_cnt - fe0, tbl[i].exp_err ? 1 : 0);
        end

        // Truncated frame abandoned by the timeout
        cv0 = cv_cnt;
        fe0 = fe_cnt;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 4);
        wait_cyc(TIMEOUT_CYCLES + 10);
        check("timeout_fe", fe_cnt - fe0, 1);
        check("timeout_cv", cv_cnt - cv0, 0);
        send_frame(8'h1D, 1'b0, 1'b0, 1'b0, 11);
        check("after_timeout_dir", 32'(dir_now()), 32'b1000);
        check("after_timeout_scan", 32'(bus.scan_code), 32'h1D);

        cv0 = cv_cnt;
        fe0 = fe_cnt;
        send_frame(8'h1B, 1'b0, 1'b1, 1'b0, 11);
        check("bad_stop_fe", fe_cnt - fe0, 1);
        check("bad_stop_cv", cv_cnt - cv0, 0);
        check("bad_stop_scan", 32'(bus.scan_code), 32'h1D);
        check("bad_stop_dir", 32'(dir_now()), 32'b1000);

        // Short low pulses on the clock line, idle and inside a frame
        cv0 = cv_cnt;
        fe0 = fe_cnt;
        for (int g = 0; g < 3; g++) begin
            bus.ps2_clk = 1'b0;
            wait_cyc(2);
            bus.ps2_clk = 1'b1;
            wait_cyc(10);
        end
        wait_cyc(20);
        check("idle_glitch_cv", cv_cnt - cv0, 0);
        check("idle_glitch_fe", fe_cnt - fe0, 0);
        send_frame(8'h23, 1'b0, 1'b0, 1'b1, 11);
        check("glitch_frame_scan", 32'(bus.scan_code), 32'h23);
        check("glitch_frame_dir", 32'(dir_now()), 32'b1010);
        check("glitch_frame_cv", cv_cnt - cv0, 1);
        check("glitch_frame_fe", fe_cnt - fe0, 0);

        // Asynchronous reset in the middle of a frame
        check("pre_reset_right", 32'(bus.right), 32'd1);
        send_frame(8'h75, 1'b0, 1'b0, 1'b0, 5);
        #2;
        resetN = 1'b0;
        #1;
        check("async_reset_dir", 32'(dir_now()), 32'd0);
        check("async_reset_scan", 32'(bus.scan_code), 32'h00);
        check("async_reset_cv", 32'(bus.code_valid), 32'd0);
        check("async_reset_fe", 32'(bus.frame_err), 32'd0);
        wait_cyc(4);
        resetN = 1'b1;
        wait_cyc(10);
        model_reset();
        send_and_check(8'hE0, 1'b0, 1'b0);
        send_and_check(8'h74, 1'b0, 1'b0);
        check("post_reset_right", 32'(bus.right), 32'd1);

        for (int r = 0; r < 40; r++) begin
            pick = int'($urandom_range(0, 11));
            if (pick < 10) code = POOL[pick];
            else           code = 8'($urandom_range(0, 255));
            send_and_check(code, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_arrow_decoder.md
# ps2_arrow_decoder

PS/2 keyboard receiver and key decoder producing the held-key direction levels `up`, `down`, `right`, `left` consumed by the snake movement logic. It samples the raw PS/2 clock/data lines and deframes 11-bit device-to-host frames. It tracks the `E0` (extended) and `F0` (break) prefixes, so each direction output is high exactly while its arrow key or WASD key is held. It sits between the board PS/2 pins and the movement block, in the `clk` domain.

## Interface
- `FILTER_LEN`, 4: consecutive identical synchronized samples required before filtered `ps2_clk` changes level.
- `TIMEOUT_CYCLES`, 50000: maximum `clk` cycles between falling edges inside a frame before the frame is abandoned.
- `clk`  in  1  system clock (50 MHz nominal).
- `resetN`  in  1  reset `resetN`, asynchronous, active-low; clock `clk`.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous to `clk`.
- `ps2_data`  in  1  raw PS/2 data, asynchronous to `clk`.
- `up`, `down`, `right`, `left`  out  1 each  high while the corresponding key is held.
- `scan_code`  out  8  last correctly received byte, held until the next one.
- `code_valid`  out  1  one-cycle pulse when `scan_code` updates.
- `frame_err`  out  1  one-cycle pulse on parity error, bad stop bit or timeout.

## Operation
- Input conditioning:
  - Both inputs pass through 2-flop synchronizers.
  - Synchronized `ps2_clk` feeds a counter filter. The filtered level toggles only after `FILTER_LEN` consecutive samples differ from the current filtered level. The counter clears on any sample equal to the current level.
  - The filtered level resets to 1.
  - A falling edge of the filtered clock produces a one-cycle `fall` strobe. Synchronized data is sampled on `fall`.
- Frame FSM, states IDLE, DATA, PARITY, STOP:
  - IDLE: on `fall` with data=0 (start bit), go to DATA and clear the bit count. On `fall` with data=1, stay in IDLE (spurious edge).
  - DATA: shift 8 bits, LSB first, into the shift register. After the 8th bit, go to PARITY.
  - PARITY: capture the bit. Odd parity is required: XOR of the 8 data bits and the parity bit must be 1. Go to STOP.
  - STOP: on `fall`, the frame is good if parity is OK and stop=1. Then pulse `code_valid`, load `scan_code`, and run the decoder. Otherwise pulse `frame_err` and leave `scan_code` unchanged. In both cases return to IDLE.
  - Timeout: in any non-IDLE state, a 16-bit-minimum counter counts cycles since the last `fall`. When it reaches `TIMEOUT_CYCLES`, pulse `frame_err`, discard the partial byte and return to IDLE. The counter clears on every `fall`.
- Decoder, on each good byte:
  - `E0`: set `ext`, no other change.
  - `F0`: set `brk`, no other change.
  - Any other byte is a key code. Drive level := !`brk` for the matching output, then clear both `ext` and `brk`.
  - Extended map (`ext`=1): `75` up, `72` down, `74` right, `6B` left.
  - Non-extended map (`ext`=0): `1D` (W) up, `1B` (S) down, `23` (D) right, `1C` (A) left.
  - Unmapped codes change no output but still clear the prefixes.
  - `frame_err` also clears `ext` and `brk`.
- Outputs are independent. Several may be high at once; arbitration belongs to the consumer. Typematic repeats of a make code re-assert an already-high level with no visible change.
- Reset mid-frame: FSM returns to IDLE; partial byte, prefixes, filter and timeout counter are cleared.

## Timing
- Reset values:
  - `up`, `down`, `right`, `left`, `code_valid`, `frame_err` = 0.
  - `scan_code` = 8'h00.
  - FSM = IDLE; `ext`, `brk` = 0; filtered clock = 1.
- Latency from a raw `ps2_clk` fall to `fall`: 2 synchronizer cycles + `FILTER_LEN` cycles + 1 edge-detect cycle, i.e. 7 cycles at default.
- `code_valid`, `frame_err`, `scan_code` and the direction outputs are all registered. They update on the clock edge following the stop-bit `fall` cycle.
- `code_valid` and `frame_err` are never high in the same cycle, and each lasts exactly one cycle.
- Glitches on `ps2_clk` shorter than `FILTER_LEN` cycles produce no `fall`.

## Test plan
- Make/break arrow: send `E0`,`75` and check `up`=1 after the second `code_valid`, other outputs 0. Then send `E0`,`F0`,`75` and check `up`=0.
- WASD and overlap: send `1C` then `1B` and check `left`=1 and `down`=1 together. Send `F0`,`1C` and check `left`=0 while `down` stays 1.
- Parity error: send `E0` with wrong parity and check `frame_err` pulse, no `code_valid`, `scan_code` unchanged. Then send `75` and check `up` stays 0, because `ext` was cleared and non-extended `75` is unmapped.
- Timeout: send a start bit and 3 data bits, then idle for `TIMEOUT_CYCLES`+10 cycles. Check a single `frame_err` pulse. A following good frame `1D` must set `up`.
- Glitch rejection: insert 2-cycle low pulses on `ps2_clk` during IDLE and mid-frame. Check the byte decodes correctly and no extra bit is shifted in.
- Reset mid-frame: assert `resetN`=0 after 5 bits of a frame with `right`=1. Check all outputs are 0 immediately (asynchronous). After release, a full `E0`,`74` sets `right`=1.
